// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, defaults, FSM state and pipeline register types for the MIPS memory stage
package mips_pkg;

  localparam int DATA_W         = 32;
  localparam int REG_W          = 5;
  localparam int MEM_DEPTH_DEF  = 64;
  localparam int ACCESS_LAT_DEF = 2;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] aluresult;
    logic              zero;
    logic [DATA_W-1:0] addresult;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  rd;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              reg_write;
    logic              mem_to_reg;
  } ex_entry_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] aluresult;
    logic [REG_W-1:0]  rd;
  } wb_entry_t;

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-addressed data memory, synchronous write and combinational read, no reset
module data_memory
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: EX/MEM and MEM/WB registers with an ACCESS_LAT-cycle data memory access
// Optional MEM_MISALIGN_TRAP_EN traps memory ops whose aluresult[1:0] is nonzero.
module mem_stage
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int ACCESS_LAT = ACCESS_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] aluresult,
  input  logic              zero,
  input  logic [DATA_W-1:0] addresult,
  input  logic [DATA_W-1:0] alureaddata2,
  input  logic [REG_W-1:0]  rd_or_rt,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              in_valid,
  output logic              stall,
  output logic              pcsrc,
  output logic [DATA_W-1:0] branch_target,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [DATA_W-1:0] wb_readdata,
  output logic [DATA_W-1:0] wb_aluresult,
  output logic [REG_W-1:0]  wb_rd
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  localparam int         AW          = $clog2(MEM_DEPTH);
  localparam logic [1:0] CNT_LAST    = 2'(ACCESS_LAT - 1);
  localparam bit         MULTI_CYCLE = (ACCESS_LAT > 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  ex_entry_t         ex_q, ex_d;
  wb_entry_t         wb_q, wb_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              in_memop, bad_addr, do_store, do_load;

  assign stall         = (state_q == ACCESS) && (cnt_q < CNT_LAST);
  assign pcsrc         = ex_q.valid && ex_q.branch && ex_q.zero;
  assign branch_target = ex_q.addresult;
  assign in_memop      = in_valid && (MemRead || MemWrite);

`ifdef MEM_MISALIGN_TRAP_EN
  logic ex_memop;
  logic misaligned_q, misaligned_d;
  assign ex_memop   = ex_q.valid && (ex_q.mem_read || ex_q.mem_write);
  assign bad_addr   = ex_memop && (ex_q.aluresult[1:0] != 2'b00);
  assign misaligned = misaligned_q;
  always_comb begin
    misaligned_d = misaligned_q;
    if (!stall) misaligned_d = bad_addr;
  end
`else
  assign bad_addr = 1'b0;
`endif

  // Both MemRead and MemWrite set is treated as a store only.
  assign do_store = !stall && ex_q.valid && ex_q.mem_write && !bad_addr;
  assign do_load  = ex_q.valid && ex_q.mem_read && !ex_q.mem_write && !bad_addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!stall && in_memop && MULTI_CYCLE) begin
      state_d = ACCESS;
      cnt_d   = 2'd0;
    end else if (stall) begin
      cnt_d = cnt_q + 2'd1;
    end else begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end
  end

  always_comb begin
    ex_d = ex_q;
    if (!stall) begin
      ex_d = '{valid: in_valid, aluresult: aluresult, zero: zero, addresult: addresult,
               wdata: alureaddata2, rd: rd_or_rt, mem_read: MemRead, mem_write: MemWrite,
               branch: Branch, reg_write: RegWrite, mem_to_reg: MemtoReg};
    end
  end

  always_comb begin
    wb_d = wb_q;
    if (!stall) begin
      wb_d.valid      = ex_q.valid;
      wb_d.reg_write  = ex_q.valid && ex_q.reg_write && !bad_addr;
      wb_d.mem_to_reg = ex_q.mem_to_reg;
      wb_d.readdata   = do_load ? mem_rdata : '0;
      wb_d.aluresult  = ex_q.aluresult;
      wb_d.rd         = ex_q.rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ex_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      wb_q    <= wb_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misaligned_q <= 1'b0;
    else        misaligned_q <= misaligned_d;
  end
`endif

  assign wb_valid     = wb_q.valid;
  assign wb_RegWrite  = wb_q.reg_write;
  assign wb_MemtoReg  = wb_q.mem_to_reg;
  assign wb_readdata  = wb_q.readdata;
  assign wb_aluresult = wb_q.aluresult;
  assign wb_rd        = wb_q.rd;

  data_memory #(
    .MEM_DEPTH(MEM_DEPTH),
    .AW       (AW)
  ) u_data_memory (
    .clk  (clk),
    .we   (do_store),
    .addr (ex_q.aluresult[AW+1:2]),
    .wdata(ex_q.wdata),
    .rdata(mem_rdata)
  );

endmodule
